scan_scheduler: RTL and testbench

SCAN_SCHEDULER -- requirements
Module: scan_scheduler

---
 rtl/scan_scheduler.sv | 166 ++++++++++++++++
 tb/tb_scan_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_scheduler.sv
// scan_scheduler: walks a SW_WIRE_CNT x RD_WIRE_CNT taxel matrix. For each taxel
// it lets the muxes settle, requests one ADC conversion, waits for the result
// with retries on error or timeout, and writes the value into a frame buffer.
//
// ADC handshake: adc_start_out is a one-cycle request. adc_valid_in and
// adc_error_in are single-cycle responses that are only looked at while
// waiting; if both are high in the same cycle, the error wins. There is no
// ready: the scheduler always accepts a response while it is waiting.
module scan_scheduler #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_RETRY   = 2
) (
  input  logic                                       clk_in,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       continuous,
  input  logic                                       abort,
  input  logic                                       adc_valid_in,
  input  logic                                       adc_error_in,
  input  logic [11:0]                                adc_data_in,
  output logic [$clog2(SW_WIRE_CNT)-1:0]             sw_mux_sel,
  output logic [$clog2(RD_WIRE_CNT)-1:0]             rd_mux_sel,
  output logic                                       adc_start_out,
  output logic                                       wr_en_out,
  output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] wr_addr_out,
  output logic [11:0]                                wr_data_out,
  output logic                                       busy_out,
  output logic                                       frame_done_out,
  output logic                                       fault_out
);

  localparam int SWW  = $clog2(SW_WIRE_CNT);
  localparam int RDW  = $clog2(RD_WIRE_CNT);
  localparam int AW   = $clog2(SW_WIRE_CNT*RD_WIRE_CNT);
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CONVERT = 3'd2,
    S_WAIT    = 3'd3,
    S_WRITE   = 3'd4,
    S_ADVANCE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [SWW-1:0]    sw_q, sw_d;
  logic [RDW-1:0]    rd_q, rd_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [TC_W-1:0]   tmo_q, tmo_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [11:0]       data_q, data_d;
  logic              fault_q, fault_d;

  logic settle_last, rd_last, sw_last, frame_end;
  logic adc_ok, adc_fail, retry_ok;

  assign settle_last = (settle_q == SC_W'(SETTLE_CYC - 1));
  assign rd_last     = (rd_q == RDW'(RD_WIRE_CNT - 1));
  assign sw_last     = (sw_q == SWW'(SW_WIRE_CNT - 1));
  assign frame_end   = rd_last && sw_last;
  assign adc_fail    = (state_q == S_WAIT) &&
                       (adc_error_in || (!adc_valid_in && tmo_q == TC_W'(TIMEOUT_CYC - 1)));
  assign adc_ok      = (state_q == S_WAIT) && adc_valid_in && !adc_error_in;
  assign retry_ok    = (retry_q < RC_W'(MAX_RETRY));

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sw_q     <= '0;
      rd_q     <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      rd_q     <= rd_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic; abort beats every other event, start included.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_SETTLE;
        S_SETTLE:  if (settle_last) state_d = S_CONVERT;
        S_CONVERT: state_d = S_WAIT;
        S_WAIT: begin
          if (adc_fail)    state_d = retry_ok ? S_CONVERT : S_WRITE;
          else if (adc_ok) state_d = S_WRITE;
        end
        S_WRITE:   state_d = S_ADVANCE;
        S_ADVANCE: state_d = (frame_end && !continuous) ? S_IDLE : S_SETTLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: counters, mux selects, captured sample and sticky fault.
  always_comb begin
    sw_d     = sw_q;
    rd_d     = rd_q;
    data_d   = data_q;
    fault_d  = fault_q;
    retry_d  = retry_q;
    settle_d = (state_q == S_SETTLE) ? settle_q + 1'b1 : '0;
    tmo_d    = (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;
    if (!abort) begin
      if (state_q == S_IDLE && start) begin
        sw_d    = '0;
        rd_d    = '0;
        fault_d = 1'b0;
      end
      if (adc_ok) data_d = adc_data_in;
      if (adc_fail) begin
        if (retry_ok) begin
          retry_d = retry_q + 1'b1;
        end else begin
          data_d  = 12'hFFF;
          fault_d = 1'b1;
        end
      end
      if (state_q == S_ADVANCE) begin
        if (!rd_last) begin
          rd_d = rd_q + 1'b1;
        end else begin
          rd_d = '0;
          if (!sw_last)        sw_d = sw_q + 1'b1;
          else if (continuous) sw_d = '0;
        end
      end
      if (state_d == S_SETTLE && state_q != S_SETTLE) retry_d = '0;
    end
  end

  // Outputs decoded from the state; strobes are squashed by abort.
  always_comb begin
    busy_out       = (state_q != S_IDLE);
    adc_start_out  = (state_q == S_CONVERT) && !abort;
    wr_en_out      = (state_q == S_WRITE) && !abort;
    frame_done_out = (state_q == S_ADVANCE) && frame_end && !abort;
    sw_mux_sel     = sw_q;
    rd_mux_sel     = rd_q;
    wr_addr_out    = AW'(sw_q) * AW'(RD_WIRE_CNT) + AW'(rd_q);
    wr_data_out    = data_q;
    fault_out      = fault_q;
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// tb_scan_scheduler: directed bench for scan_scheduler on a 4x4 matrix with a
// behavioural ADC, a write scoreboard built from per-taxel ADC behaviour, and
// hand-computed cycle-level expectations.
module tb_scan_scheduler;

  localparam int SW = 4;
  localparam int RD = 4;
  localparam int SC = 2;
  localparam int TO = 8;
  localparam int MR = 1;
  localparam int N  = SW * RD;

  // ADC behaviour per taxel
  localparam int M_OK    = 0;  // valid 3 cycles after request
  localparam int M_ERR1  = 1;  // error on first attempt, then valid
  localparam int M_DEAD  = 2;  // never answers
  localparam int M_BOTH1 = 3;  // valid+error together first, then valid

  logic        clk = 1'b0;
  logic        rst, start, continuous, abort;
  logic        adc_valid_in, adc_error_in;
  logic [11:0] adc_data_in;
  logic [1:0]  sw_mux_sel, rd_mux_sel;
  logic        adc_start_out, wr_en_out, busy_out, frame_done_out, fault_out;
  logic [3:0]  wr_addr_out;
  logic [11:0] wr_data_out;

  scan_scheduler #(
    .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .SETTLE_CYC(SC),
    .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut (
    .clk_in(clk), .rst(rst), .start(start), .continuous(continuous),
    .abort(abort), .adc_valid_in(adc_valid_in), .adc_error_in(adc_error_in),
    .adc_data_in(adc_data_in), .sw_mux_sel(sw_mux_sel), .rd_mux_sel(rd_mux_sel),
    .adc_start_out(adc_start_out), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .fault_out(fault_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int mode [N];
  int att  [N];
  int first_st [N];
  int last_st  [N];
  int wr_cyc   [N];
  int start_cnt, done_cnt, wr_count, last_wr;
  logic [15:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      mode[i] = M_OK; att[i] = 0;
      first_st[i] = -1; last_st[i] = -1; wr_cyc[i] = -1;
    end
    start_cnt = 0; done_cnt = 0; wr_count = 0; last_wr = -100;
  endtask

  // One frame's worth of expected writes: every taxel in order, a dead
  // taxel reads as all-ones, everything else reads back its own address.
  task automatic push_frame(int upto);
    logic [15:0] e;
    for (int a = 0; a < upto; a++) begin
      e[15:12] = 4'(a);
      e[11:0]  = (mode[a] == M_DEAD) ? 12'hFFF : 12'(a);
      exp_q.push_back(e);
    end
  endtask

  // Conversions expected in a frame: one per healthy taxel, two for a taxel
  // that fails once, 1+MAX_RETRY for a taxel that never answers.
  function automatic int exp_starts();
    int s = 0;
    for (int a = 0; a < N; a++)
      s += (mode[a] == M_OK) ? 1 : (mode[a] == M_DEAD) ? 1 + MR : 2;
    return s;
  endfunction

  task automatic pulse_start(output int sc_cyc);
    sc_cyc = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int k = 0;
    while (!frame_done_out && k < budget) begin tick(1); k++; end
    check(name, 32'(frame_done_out), 1);
  endtask

  task automatic wait_start_at(int addr, int budget);
    int k = 0;
    while (!(adc_start_out && wr_addr_out == 4'(addr)) && k < budget) begin
      tick(1); k++;
    end
    check("reach_taxel", 32'(adc_start_out && wr_addr_out == 4'(addr)), 1);
  endtask

  // ---------------- ADC model ----------------
  initial begin
    int pend = 0;
    int pa = 0;
    adc_valid_in = 1'b0; adc_error_in = 1'b0; adc_data_in = '0;
    forever begin
      @(negedge clk);
      adc_valid_in = 1'b0; adc_error_in = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          case (mode[pa])
            M_OK: begin adc_valid_in = 1'b1; adc_data_in = 12'(pa); end
            M_ERR1: begin
              if (att[pa] == 1) adc_error_in = 1'b1;
              else begin adc_valid_in = 1'b1; adc_data_in = 12'(pa); end
            end
            M_BOTH1: begin
              adc_valid_in = 1'b1;
              if (att[pa] == 1) begin adc_error_in = 1'b1; adc_data_in = 12'hABC; end
              else adc_data_in = 12'(pa);
            end
            default: ;
          endcase
        end
      end
      if (adc_start_out && !rst) begin
        pa = int'(wr_addr_out);
        att[pa]++;
        pend = 3;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (adc_start_out) begin
          if (first_st[wr_addr_out] < 0) first_st[wr_addr_out] = cyc;
          last_st[wr_addr_out] = cyc;
          start_cnt++;
        end
        if (wr_en_out) begin
          wr_count++;
          wr_cyc[wr_addr_out] = cyc;
          last_wr = cyc;
          check("wr_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr_out), 32'(e[15:12]));
            check("wr_data", 32'(wr_data_out), 32'(e[11:0]));
          end
          check("wr_while_busy", 32'(busy_out), 1);
        end
        if (frame_done_out) begin
          done_cnt++;
          check("done_after_last_wr", 32'(cyc - last_wr), 1);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int sc_cyc, t, k;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    clear_model();
    tick(2);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_sw", 32'(sw_mux_sel), 0);
    check("rst_rd", 32'(rd_mux_sel), 0);
    check("rst_strobes", 32'({adc_start_out, wr_en_out, frame_done_out, fault_out}), 0);
    check("rst_wr_bus", 32'({wr_addr_out, wr_data_out}), 0);
    rst = 1'b0;
    tick(2);

    // start together with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy_out), 0);

    // T1: plain frame, plus a stray start while busy
    clear_model();
    push_frame(N);
    pulse_start(sc_cyc);
    tick(30);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done("t1_done", 400);
    tick(2);
    check("t1_first_conv_lat", 32'(first_st[0] - sc_cyc), 3);
    check("t1_taxel_period", 32'(first_st[1] - first_st[0]), 8);
    check("t1_wr_lat", 32'(wr_cyc[0] - first_st[0]), 4);
    check("t1_starts", 32'(start_cnt), 32'(exp_starts()));
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_writes", 32'(wr_count), 16);
    check("t1_queue_empty", 32'(exp_q.size()), 0);
    check("t1_idle", 32'(busy_out), 0);
    check("t1_fault", 32'(fault_out), 0);

    // T2: error at taxel 5, valid+error at taxel 3
    clear_model();
    mode[5] = M_ERR1; mode[3] = M_BOTH1;
    push_frame(N);
    pulse_start(sc_cyc);
    wait_done("t2_done", 400);
    tick(2);
    check("t2_starts", 32'(start_cnt), 32'(exp_starts()));
    check("t2_starts_literal", 32'(start_cnt), 18);
    check("t2_retry_gap", 32'(last_st[5] - first_st[5]), 4);
    check("t2_queue_empty", 32'(exp_q.size()), 0);
    check("t2_fault", 32'(fault_out), 0);

    // T3: taxel 9 never answers
    clear_model();
    mode[9] = M_DEAD;
    push_frame(N);
    pulse_start(sc_cyc);
    wait_done("t3_done", 500);
    tick(2);
    check("t3_starts", 32'(start_cnt), 17);
    check("t3_timeout_gap", 32'(last_st[9] - first_st[9]), 9);
    check("t3_dead_wr_lat", 32'(wr_cyc[9] - first_st[9]), 18);
    check("t3_reached_15", 32'(wr_cyc[15] > 0), 1);
    check("t3_queue_empty", 32'(exp_q.size()), 0);
    check("t3_fault", 32'(fault_out), 1);
    check("t3_hold_sw", 32'(sw_mux_sel), 3);
    check("t3_hold_rd", 32'(rd_mux_sel), 0);

    // T4: two continuous frames; new start clears the fault
    clear_model();
    push_frame(N);
    push_frame(N);
    continuous = 1'b1;
    pulse_start(sc_cyc);
    tick(2);
    check("t4_fault_cleared", 32'(fault_out), 0);
    wait_done("t4_done1", 400);
    t = cyc;
    k = 0;
    tick(1); k++;
    continuous = 1'b0;
    while (!adc_start_out && k < 10) begin tick(1); k++; end
    check("t4_wrap_gap", 32'(cyc - t), 3);
    check("t4_wrap_addr", 32'(wr_addr_out), 0);
    tick(1);
    wait_done("t4_done2", 400);
    tick(2);
    check("t4_done_cnt", 32'(done_cnt), 2);
    check("t4_writes", 32'(wr_count), 32);
    check("t4_queue_empty", 32'(exp_q.size()), 0);
    check("t4_idle", 32'(busy_out), 0);

    // T5: abort while waiting at taxel 6
    clear_model();
    push_frame(6);
    pulse_start(sc_cyc);
    wait_start_at(6, 200);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_idle_next", 32'(busy_out), 0);
    check("t5_hold_sw", 32'(sw_mux_sel), 1);
    check("t5_hold_rd", 32'(rd_mux_sel), 2);
    tick(20);
    check("t5_writes", 32'(wr_count), 6);
    check("t5_no_done", 32'(done_cnt), 0);
    check("t5_queue_empty", 32'(exp_q.size()), 0);

    // T6: reset while waiting at taxel 6
    clear_model();
    push_frame(6);
    pulse_start(sc_cyc);
    wait_start_at(6, 200);
    tick(1);
    rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy_out), 0);
    check("t6_sel", 32'({sw_mux_sel, rd_mux_sel}), 0);
    check("t6_wr_bus", 32'({wr_addr_out, wr_data_out}), 0);
    check("t6_strobes", 32'({adc_start_out, wr_en_out, frame_done_out, fault_out}), 0);
    tick(1);
    rst = 1'b0;
    tick(40);
    check("t6_writes", 32'(wr_count), 6);
    check("t6_no_done", 32'(done_cnt), 0);
    check("t6_idle", 32'(busy_out), 0);
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
